trd_hazard_ctrl: RTL and testbench

- Parametrised flush/stall and thread-state controller for the barrel-threaded pipeline.
- Generalises the fixed 5-stage flush logic to NUM_STG stages and NUM_TRD threads, with per-stage valid qualification.
- Allows a writeback-stage event and a jump flush in the same cycle.
- Adds a registered per-thread state machine (RUN/MISS/SLEEP/DEAD) that drives the fetch-eligibility mask, so parked threads are not fetched until woken, refilled or spawned.

---
 rtl/trd_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_trd_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trd_hazard_ctrl.sv
// rtl/trd_hazard_ctrl.sv - flush/stall and per-thread state controller for the barrel-threaded pipeline
module trd_hazard_ctrl #(
  parameter int                 NUM_TRD  = 8,
  parameter int                 TRD_W    = 3,
  parameter int                 NUM_STG  = 5,
  parameter int                 JMP_STG  = 2,
  parameter logic [NUM_TRD-1:0] RST_MASK = 8'h01
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_STG*TRD_W-1:0]   trd_stg,
  input  logic [NUM_STG-1:0]         vld_stg,
  input  logic                       kill,
  input  logic                       sleep,
  input  logic                       d_miss,
  input  logic                       jmp,
  input  logic                       stall_req,
  input  logic                       d_fill,
  input  logic [TRD_W-1:0]           fill_trd,
  input  logic                       wake,
  input  logic [TRD_W-1:0]           wake_trd,
  input  logic                       spawn,
  input  logic [TRD_W-1:0]           spawn_trd,
  output logic [NUM_STG-1:0]         flush,
  output logic                       stall,
  output logic [NUM_TRD-1:0]         trd_active,
  output logic [2*NUM_TRD-1:0]       trd_state
);

  localparam int WB = NUM_STG - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_SLEEP = 2'd2,
    ST_DEAD  = 2'd3
  } trd_st_e;

  trd_st_e            st_q [NUM_TRD];
  trd_st_e            st_d [NUM_TRD];
  logic [NUM_TRD-1:0] act_d;
  logic [NUM_TRD-1:0] act_q;

  logic [TRD_W-1:0]   wt;
  logic [TRD_W-1:0]   jt;
  logic               wb_ev;
  logic               jmp_ok;
  logic [NUM_STG-1:0] ev_flush;
  logic [NUM_STG-1:0] jmp_flush;

  assign wt    = trd_stg[WB*TRD_W +: TRD_W];
  assign jt    = trd_stg[JMP_STG*TRD_W +: TRD_W];
  assign wb_ev = vld_stg[WB] & (kill | sleep | d_miss);

  // WB event squashes every valid younger instruction of the same thread; WB itself retires or replays
  always_comb begin
    ev_flush = '0;
    for (int s = 0; s < WB; s++) begin
      ev_flush[s] = wb_ev & vld_stg[s] & (trd_stg[s*TRD_W +: TRD_W] == wt);
    end
  end

  // a jump that was itself squashed by the WB event must not redirect its thread
  assign jmp_ok = jmp & vld_stg[JMP_STG] & ~ev_flush[JMP_STG];

  // taken jump squashes the valid same-thread instructions fetched behind it
  always_comb begin
    jmp_flush = '0;
    for (int s = 0; s < JMP_STG; s++) begin
      jmp_flush[s] = jmp_ok & vld_stg[s] & (trd_stg[s*TRD_W +: TRD_W] == jt);
    end
  end

  assign flush = ev_flush | jmp_flush;
  assign stall = stall_req & ~(|flush);

  // per-thread next state: releases only from their own parked state, WB event overrides everything
  always_comb begin
    act_d = '0;
    for (int t = 0; t < NUM_TRD; t++) begin
      st_d[t] = st_q[t];
      case (st_q[t])
        ST_MISS:  if (d_fill && fill_trd == TRD_W'(t))  st_d[t] = ST_RUN;
        ST_SLEEP: if (wake   && wake_trd == TRD_W'(t))  st_d[t] = ST_RUN;
        ST_DEAD:  if (spawn  && spawn_trd == TRD_W'(t)) st_d[t] = ST_RUN;
        default:  st_d[t] = st_q[t];
      endcase
      if (wb_ev && wt == TRD_W'(t)) begin
        if (kill)       st_d[t] = ST_DEAD;
        else if (sleep) st_d[t] = ST_SLEEP;
        else            st_d[t] = ST_MISS;
      end
      act_d[t] = (st_d[t] == ST_RUN);
    end
  end

  // thread state and fetch mask registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        st_q[t] <= RST_MASK[t] ? ST_RUN : ST_DEAD;
      end
      act_q <= RST_MASK;
    end else begin
      for (int t = 0; t < NUM_TRD; t++) begin
        st_q[t] <= st_d[t];
      end
      act_q <= act_d;
    end
  end

  // pack thread states onto the output bus
  always_comb begin
    trd_state = '0;
    for (int t = 0; t < NUM_TRD; t++) begin
      trd_state[2*t +: 2] = st_q[t];
    end
  end

  assign trd_active = act_q;

endmodule

// File: tb/tb_trd_hazard_ctrl.sv
// tb/tb_trd_hazard_ctrl.sv - randomized and directed bench for trd_hazard_ctrl
module tb_trd_hazard_ctrl;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = 3;
  localparam int NUM_STG = 5;
  localparam int JMP_STG = 2;
  localparam int WB      = NUM_STG - 1;
  localparam logic [NUM_TRD-1:0] RST_MASK = 8'h01;

  logic                     clk = 0;
  logic                     rst;
  logic [NUM_STG*TRD_W-1:0] trd_stg;
  logic [NUM_STG-1:0]       vld_stg;
  logic kill, sleep, d_miss, jmp, stall_req, d_fill, wake, spawn;
  logic [TRD_W-1:0] fill_trd, wake_trd, spawn_trd;
  logic [NUM_STG-1:0]   flush;
  logic                 stall;
  logic [NUM_TRD-1:0]   trd_active;
  logic [2*NUM_TRD-1:0] trd_state;

  int checks = 0;
  int errors = 0;

  int m_st [NUM_TRD];

  trd_hazard_ctrl #(
    .NUM_TRD(NUM_TRD), .TRD_W(TRD_W), .NUM_STG(NUM_STG),
    .JMP_STG(JMP_STG), .RST_MASK(RST_MASK)
  ) dut (
    .clk(clk), .rst(rst), .trd_stg(trd_stg), .vld_stg(vld_stg),
    .kill(kill), .sleep(sleep), .d_miss(d_miss), .jmp(jmp),
    .stall_req(stall_req), .d_fill(d_fill), .fill_trd(fill_trd),
    .wake(wake), .wake_trd(wake_trd), .spawn(spawn), .spawn_trd(spawn_trd),
    .flush(flush), .stall(stall), .trd_active(trd_active), .trd_state(trd_state)
  );

  always #5 clk = ~clk;

  function automatic int stg_trd(int s);
    logic [TRD_W-1:0] v;
    v = trd_stg[s*TRD_W +: TRD_W];
    return int'(v);
  endfunction

  // list the flushed stages from the two rules, then OR them
  function automatic logic [NUM_STG-1:0] exp_flush();
    logic [NUM_STG-1:0] f;
    bit ev, jmp_dead;
    f = '0;
    ev = vld_stg[WB] && (kill || sleep || d_miss);
    jmp_dead = 0;
    if (ev) begin
      for (int s = 0; s < WB; s++) begin
        if (vld_stg[s] && stg_trd(s) == stg_trd(WB)) begin
          f[s] = 1'b1;
          if (s == JMP_STG) jmp_dead = 1;
        end
      end
    end
    if (jmp && vld_stg[JMP_STG] && !jmp_dead) begin
      for (int s = 0; s < JMP_STG; s++) begin
        if (vld_stg[s] && stg_trd(s) == stg_trd(JMP_STG)) f[s] = 1'b1;
      end
    end
    return f;
  endfunction

  function automatic logic [2*NUM_TRD-1:0] exp_state();
    logic [2*NUM_TRD-1:0] v;
    for (int t = 0; t < NUM_TRD; t++) v[2*t +: 2] = 2'(m_st[t]);
    return v;
  endfunction

  function automatic logic [NUM_TRD-1:0] exp_active();
    logic [NUM_TRD-1:0] v;
    for (int t = 0; t < NUM_TRD; t++) v[t] = (m_st[t] == 0);
    return v;
  endfunction

  // reference model: apply releases first, then let a WB event overwrite its thread
  always @(posedge clk or posedge rst) begin
    int nxt [NUM_TRD];
    if (rst) begin
      for (int t = 0; t < NUM_TRD; t++) m_st[t] <= RST_MASK[t] ? 0 : 3;
    end else begin
      nxt = m_st;
      if (d_fill && int'(fill_trd) < NUM_TRD && m_st[int'(fill_trd)] == 1) nxt[int'(fill_trd)] = 0;
      if (wake && int'(wake_trd) < NUM_TRD && m_st[int'(wake_trd)] == 2) nxt[int'(wake_trd)] = 0;
      if (spawn && int'(spawn_trd) < NUM_TRD && m_st[int'(spawn_trd)] == 3) nxt[int'(spawn_trd)] = 0;
      if (vld_stg[WB] && (kill || sleep || d_miss) && stg_trd(WB) < NUM_TRD)
        nxt[stg_trd(WB)] = kill ? 3 : (sleep ? 2 : 1);
      m_st <= nxt;
    end
  end

  // every cycle out of reset: outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (flush !== exp_flush()) begin
        errors++;
        $display("FAIL model_flush got %b want %b at %0t", flush, exp_flush(), $time);
      end
      checks++;
      if (stall !== (stall_req && exp_flush() == '0)) begin
        errors++;
        $display("FAIL model_stall got %b want %b at %0t", stall, (stall_req && exp_flush() == '0), $time);
      end
      checks++;
      if (trd_state !== exp_state()) begin
        errors++;
        $display("FAIL model_state got %h want %h at %0t", trd_state, exp_state(), $time);
      end
      checks++;
      if (trd_active !== exp_active()) begin
        errors++;
        $display("FAIL model_active got %h want %h at %0t", trd_active, exp_active(), $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    kill = 0; sleep = 0; d_miss = 0; jmp = 0; stall_req = 0;
    d_fill = 0; wake = 0; spawn = 0;
    fill_trd = 0; wake_trd = 0; spawn_trd = 0;
  endtask

  task automatic set_stg(input int a0, input int a1, input int a2, input int a3, input int a4,
                         input logic [NUM_STG-1:0] v);
    trd_stg[0*TRD_W +: TRD_W] = a0[TRD_W-1:0];
    trd_stg[1*TRD_W +: TRD_W] = a1[TRD_W-1:0];
    trd_stg[2*TRD_W +: TRD_W] = a2[TRD_W-1:0];
    trd_stg[3*TRD_W +: TRD_W] = a3[TRD_W-1:0];
    trd_stg[4*TRD_W +: TRD_W] = a4[TRD_W-1:0];
    vld_stg = v;
  endtask

  initial begin
    rst = 1;
    idle();
    set_stg(0, 0, 0, 0, 0, 5'b00000);
    repeat (2) step();
    rst = 0;

    // 1: reset values and spawn
    chk("rst_active", 32'(trd_active), 32'h01);
    chk("rst_state", 32'(trd_state), 32'hFFFC);
    spawn = 1; spawn_trd = 3;
    step();
    idle();
    chk("spawn_active", 32'(trd_active), 32'h09);
    chk("spawn_state3", 32'(trd_state[6 +: 2]), 32'd0);

    // 2: d_miss on thread 2, refill two cycles later
    set_stg(2, 5, 2, 1, 2, 5'b11111);
    d_miss = 1;
    #1;
    chk("miss_flush", 32'(flush), 32'b00101);
    chk("miss_stall", 32'(stall), 32'd0);
    step();
    idle();
    chk("miss_state2", 32'(trd_state[4 +: 2]), 32'd1);
    chk("miss_active2", 32'(trd_active[2]), 32'd0);
    step();
    d_fill = 1; fill_trd = 2;
    step();
    idle();
    chk("fill_state2", 32'(trd_state[4 +: 2]), 32'd0);
    chk("fill_active2", 32'(trd_active[2]), 32'd1);

    // 3: jump on thread 4 plus kill of thread 1 together
    set_stg(4, 4, 4, 6, 1, 5'b11111);
    jmp = 1; kill = 1;
    #1;
    chk("jmpkill_flush", 32'(flush), 32'b00011);
    step();
    idle();
    chk("kill_state1", 32'(trd_state[2 +: 2]), 32'd3);

    // 4: sleep of thread 3 squashes EX so its jump is ignored; same-cycle wake is lost
    set_stg(3, 0, 3, 5, 3, 5'b11111);
    sleep = 1; jmp = 1; wake = 1; wake_trd = 3;
    #1;
    chk("sleep_flush", 32'(flush), 32'b00101);
    step();
    idle();
    chk("sleep_state3", 32'(trd_state[6 +: 2]), 32'd2);
    chk("sleep_active3", 32'(trd_active[3]), 32'd0);
    wake = 1; wake_trd = 3;
    step();
    idle();
    chk("wake_state3", 32'(trd_state[6 +: 2]), 32'd0);

    // 5: stall, invalid WB event, then flush overriding stall
    set_stg(7, 0, 7, 7, 0, 5'b11111);
    stall_req = 1;
    #1;
    chk("stall_only", 32'(stall), 32'd1);
    chk("stall_noflush", 32'(flush), 32'd0);
    set_stg(0, 0, 0, 0, 0, 5'b01111);
    d_miss = 1;
    #1;
    chk("inv_wb_flush", 32'(flush), 32'd0);
    chk("inv_wb_stall", 32'(stall), 32'd1);
    step();
    chk("inv_wb_state0", 32'(trd_state[1:0]), 32'd0);
    set_stg(7, 0, 7, 7, 0, 5'b11111);
    #1;
    chk("ovr_flush", 32'(flush), 32'b00010);
    chk("ovr_stall", 32'(stall), 32'd0);
    step();
    idle();
    d_fill = 1; fill_trd = 0;
    step();
    idle();

    // 6: thread 6 in MISS, async reset mid-cycle, late fill ignored
    spawn = 1; spawn_trd = 6;
    step();
    idle();
    set_stg(1, 1, 1, 1, 6, 5'b10000);
    d_miss = 1;
    step();
    idle();
    chk("pre_rst_state6", 32'(trd_state[12 +: 2]), 32'd1);
    #2 rst = 1;
    #1;
    chk("async_state6", 32'(trd_state[12 +: 2]), 32'd3);
    chk("async_active", 32'(trd_active), 32'h01);
    step();
    rst = 0;
    d_fill = 1; fill_trd = 6;
    step();
    idle();
    chk("late_fill6", 32'(trd_state[12 +: 2]), 32'd3);

    // random phase: model compares every cycle
    for (int i = 0; i < 3000; i++) begin
      trd_stg   = NUM_STG*TRD_W'($urandom);
      vld_stg   = NUM_STG'($urandom);
      kill      = ($urandom_range(0, 15) == 0);
      sleep     = ($urandom_range(0, 9) == 0);
      d_miss    = ($urandom_range(0, 5) == 0);
      jmp       = ($urandom_range(0, 3) == 0);
      stall_req = ($urandom_range(0, 2) == 0);
      d_fill    = ($urandom_range(0, 2) == 0);
      fill_trd  = TRD_W'($urandom);
      wake      = ($urandom_range(0, 2) == 0);
      wake_trd  = TRD_W'($urandom);
      spawn     = ($urandom_range(0, 3) == 0);
      spawn_trd = TRD_W'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
